// File: rtl/npc_ctrl_pkg.sv
// npc_ctrl_pkg: shared definitions for the NPC multi-cycle control path.
// stage_e is the on-wire `stage` encoding seen by the DPI bridge and datapath,
// so the numeric values are part of the interface and must not be reordered.
package npc_ctrl_pkg;

  localparam int STAGE_W = 3;

  typedef enum logic [STAGE_W-1:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6,
    S_ERR  = 3'd7
  } stage_e;

  // Instruction class captured from the decoder while in ID.
  typedef struct packed {
    logic halt;
    logic load;
    logic store;
  } instr_cls_t;

  function automatic logic cls_is_mem(instr_cls_t c);
    return c.load | c.store;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// wait_timer: counts consecutive wait cycles and flags the cycle that would
// be the LIMIT-th one.
//   clk, rst_n : clock, async active-low reset
//   clear      : zero the count (takes priority over count_en)
//   count_en   : this cycle is a wait cycle
//   expired    : this is the LIMIT-th consecutive wait cycle
// The owner leaves the waiting state when expired is seen, so the count
// never runs past LIMIT-1 and needs no saturation.
module wait_timer #(
  parameter int          W     = 16,
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)         cnt_d = '0;
    else if (count_en) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // cnt_q holds the wait cycles already spent; the current one is cnt_q+1.
  assign expired = count_en && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/stage_controller.sv
// stage_controller: multi-cycle IF/ID/EX/MEM/WB sequencer for the NPC core.
//   clk, rst_n         : clock, async active-low reset
//   start              : leave IDLE and begin fetching
//   ifu_ready          : fetch data valid (IF only)
//   mem_ready          : data memory done (MEM only)
//   halt_req, is_load,
//   is_store           : decoder class flags, sampled in ID
//   stage              : current state (stage_e encoding)
//   ifu_req, ir_we     : fetch request level / IR latch pulse
//   memReadEnable,
//   memWriteEnable     : data memory request levels, MEM only
//   pc_we, rf_we       : write-back pulses
//   halt, timeout_err  : sticky terminal flags
//   retire_cnt         : retired instruction count, wraps
// All outputs decode registered state except ir_we, which follows ifu_ready
// combinationally so the IR captures on the same edge the fetch completes.
module stage_controller
  import npc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int          RETIRE_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                ifu_ready,
  input  logic                mem_ready,
  input  logic                halt_req,
  input  logic                is_load,
  input  logic                is_store,
  output logic [STAGE_W-1:0]  stage,
  output logic                ifu_req,
  output logic                ir_we,
  output logic                memReadEnable,
  output logic                memWriteEnable,
  output logic                pc_we,
  output logic                rf_we,
  output logic                halt,
  output logic                timeout_err,
  output logic [RETIRE_W-1:0] retire_cnt
);

  stage_e              state_q, state_d;
  instr_cls_t          cls_q, cls_d;
  logic [RETIRE_W-1:0] retire_q, retire_d;
  logic                wait_cyc, wait_expired;

  assign wait_cyc = ((state_q == S_IF)  && !ifu_ready) ||
                    ((state_q == S_MEM) && !mem_ready);

  wait_timer #(
    .W     (16),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state_d != state_q),
    .count_en (wait_cyc),
    .expired  (wait_expired)
  );

  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    retire_d = retire_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_IF;
      S_IF: begin
        // A ready in the expiring cycle still wins.
        if (ifu_ready)         state_d = S_ID;
        else if (wait_expired) state_d = S_ERR;
      end
      S_ID: begin
        cls_d = '{halt: halt_req, load: is_load, store: is_store};
        if (halt_req)                  state_d = S_HALT;
        else if (is_load && is_store)  state_d = S_ERR;
        else                           state_d = S_EX;
      end
      S_EX:   state_d = cls_is_mem(cls_q) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_ready)         state_d = S_WB;
        else if (wait_expired) state_d = S_ERR;
      end
      S_WB: begin
        state_d  = S_IF;
        retire_d = retire_q + RETIRE_W'(1);
      end
      S_HALT, S_ERR: state_d = state_q;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cls_q    <= '0;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      retire_q <= retire_d;
    end
  end

  assign stage          = state_q;
  assign ifu_req        = (state_q == S_IF);
  assign ir_we          = ifu_req & ifu_ready;
  assign memReadEnable  = (state_q == S_MEM) && cls_q.load;
  assign memWriteEnable = (state_q == S_MEM) && cls_q.store;
  assign pc_we          = (state_q == S_WB);
  // A halt never reaches WB; masking on it keeps a stray path from writing.
  assign rf_we          = (state_q == S_WB) && !cls_q.store && !cls_q.halt;
  assign halt           = (state_q == S_HALT);
  assign timeout_err    = (state_q == S_ERR);
  assign retire_cnt     = retire_q;

endmodule

// File: tb/tb_stage_controller.sv
module tb_stage_controller;
  import npc_ctrl_pkg::*;

  localparam int T  = 4;
  localparam int RW = 4;

  logic clk = 0, rst_n = 1, start = 0, ifu_ready = 0, mem_ready = 0;
  logic halt_req = 0, is_load = 0, is_store = 0;
  logic [2:0] stage;
  logic ifu_req, ir_we, mre, mwe, pc_we, rf_we, halt, terr;
  logic [RW-1:0] retire_cnt;

  stage_controller #(.TIMEOUT_CYCLES(T), .RETIRE_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ifu_ready(ifu_ready),
    .mem_ready(mem_ready), .halt_req(halt_req), .is_load(is_load),
    .is_store(is_store), .stage(stage), .ifu_req(ifu_req), .ir_we(ir_we),
    .memReadEnable(mre), .memWriteEnable(mwe), .pc_we(pc_we), .rf_we(rf_we),
    .halt(halt), .timeout_err(terr), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, exp_ret = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- reference model: expected per-cycle trace ----------------
  typedef struct {
    logic [2:0] stg;
    bit ifr, mr, hr, ld, st, strt, cl, cs;
  } cyc_t;
  cyc_t plan[$];

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic push(input int stg, input bit ifr, mr, hr, ld, st, cl, cs);
    cyc_t c;
    c.stg = 3'(stg); c.ifr = ifr; c.mr = mr; c.hr = hr; c.ld = ld; c.st = st;
    c.strt = rb(); c.cl = cl; c.cs = cs;
    plan.push_back(c);
  endtask

  // One instruction: ifw/mw wait cycles before ready; >= T means it never comes.
  task automatic plan_instr(input bit hr, ld, st, input int ifw, mw, tail);
    for (int i = 0; i < T && i <= ifw; i++) push(1, i == ifw, rb(), rb(), rb(), rb(), ld, st);
    if (ifw >= T) begin repeat (tail) push(7, rb(), rb(), rb(), rb(), rb(), ld, st); return; end
    push(2, rb(), rb(), hr, ld, st, ld, st);
    if (hr) begin repeat (tail) push(6, rb(), rb(), rb(), rb(), rb(), ld, st); return; end
    if (ld && st) begin repeat (tail) push(7, rb(), rb(), rb(), rb(), rb(), ld, st); return; end
    push(3, rb(), rb(), rb(), rb(), rb(), ld, st);
    if (ld || st) begin
      for (int i = 0; i < T && i <= mw; i++) push(4, rb(), i == mw, rb(), rb(), rb(), ld, st);
      if (mw >= T) begin repeat (tail) push(7, rb(), rb(), rb(), rb(), rb(), ld, st); return; end
    end
    push(5, rb(), rb(), rb(), rb(), rb(), ld, st);
  endtask

  function automatic logic [10:0] exp_outs(cyc_t c);
    logic [2:0] s = c.stg;
    return {s, s == 3'd1, (s == 3'd1) && c.ifr, (s == 3'd4) && c.cl, (s == 3'd4) && c.cs,
            s == 3'd5, (s == 3'd5) && !c.cs, s == 3'd6, s == 3'd7};
  endfunction

  function automatic logic [10:0] outs();
    return {stage, ifu_req, ir_we, mre, mwe, pc_we, rf_we, halt, terr};
  endfunction

  // Entered at a negedge with inputs not yet driven for that cycle.
  task automatic run_plan();
    cyc_t c;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      ifu_ready = c.ifr; mem_ready = c.mr; halt_req = c.hr;
      is_load = c.ld; is_store = c.st; start = c.strt;
      #1;
      chk($sformatf("trace stage%0d outputs", c.stg), 32'(outs()), 32'(exp_outs(c)));
      chk("trace retire_cnt", 32'(retire_cnt), 32'(exp_ret % (1 << RW)));
      if (c.stg == 3'd5) exp_ret++;
      @(negedge clk);
    end
  endtask

  // ---------------- table-driven, closed-loop transactions ----------------
  typedef struct { bit ld, st; int ifw, mwt, lat, rf, nr, nw; } row_t;
  row_t rows[6];

  task automatic run_row(input int idx, input row_t r);
    int lat = 0, rfc = 0, mrc = 0, mwc = 0, ifc = 0, mc = 0;
    bit left = 0, done = 0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      if (stage == 3'd1 && left) done = 1;
      else begin
        if (stage != 3'd1) left = 1;
        ifu_ready = (stage == 3'd1) && (ifc >= r.ifw);
        mem_ready = (stage == 3'd4) && (mc >= r.mwt);
        halt_req = 0; start = 0;
        is_load = (stage == 3'd2) && r.ld;
        is_store = (stage == 3'd2) && r.st;
        if (stage == 3'd1) ifc++;
        if (stage == 3'd4) mc++;
        #1;
        lat++; rfc += int'(rf_we); mrc += int'(mre); mwc += int'(mwe);
        @(negedge clk);
      end
    end
    exp_ret++;
    chk($sformatf("row%0d completes", idx), 32'(done), 32'd1);
    chk($sformatf("row%0d latency", idx), 32'(lat), 32'(r.lat));
    chk($sformatf("row%0d rf_we cycles", idx), 32'(rfc), 32'(r.rf));
    chk($sformatf("row%0d memReadEnable cycles", idx), 32'(mrc), 32'(r.nr));
    chk($sformatf("row%0d memWriteEnable cycles", idx), 32'(mwc), 32'(r.nw));
    chk($sformatf("row%0d retire_cnt", idx), 32'(retire_cnt), 32'(exp_ret % (1 << RW)));
  endtask

  task automatic do_reset();
    rst_n = 0; start = 0; ifu_ready = 0; mem_ready = 0;
    halt_req = 0; is_load = 0; is_store = 0;
    @(negedge clk);
    rst_n = 1; exp_ret = 0;
  endtask

  task automatic kick();
    start = 1;
    #1 chk("idle before start", 32'(stage), 32'd0);
    @(negedge clk);
    start = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    //            ld st ifw mwt lat rf nr nw
    rows[0] = '{0, 0, 0, 0, 4, 1, 0, 0};   // ALU, zero wait
    rows[1] = '{1, 0, 0, 3, 8, 1, 4, 0};   // load, 3 MEM waits
    rows[2] = '{0, 1, 0, 0, 5, 0, 0, 1};   // store, immediate
    rows[3] = '{0, 0, 2, 0, 6, 1, 0, 0};   // ALU, 2 IF waits
    rows[4] = '{1, 0, 1, 1, 7, 1, 2, 0};   // load, 1+1 waits
    rows[5] = '{0, 1, 3, 3, 11, 0, 0, 4};  // store, ready on the last allowed cycle

    // Reset state
    #2 rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset outputs", 32'(outs()), 32'd0);
    chk("reset retire_cnt", 32'(retire_cnt), 32'd0);
    rst_n = 1;
    @(negedge clk);
    repeat (2) begin
      #1 chk("idle holds without start", 32'(stage), 32'd0);
      @(negedge clk);
    end
    kick();

    foreach (rows[i]) run_row(i, rows[i]);

    // Randomized instruction mix against the trace model
    for (int k = 0; k < 40; k++) begin
      int cls = int'($urandom_range(0, 2));
      plan_instr(0, cls == 1, cls == 2, int'($urandom_range(0, T - 1)),
                 int'($urandom_range(0, T - 1)), 0);
    end
    run_plan();

    // Retire counter wraps after 16 retires
    do_reset(); kick();
    repeat (16) plan_instr(0, 0, 0, 0, 0, 0);
    run_plan();
    #1 chk("retire wrap to 0", 32'(retire_cnt), 32'd0);
    @(negedge clk);

    // Halt beats load in ID; absorbing, start ignored
    plan.delete();
    ifu_ready = 1; #1; @(negedge clk);   // one more IF so the plan starts aligned
    ifu_ready = 0;
    do_reset(); kick();
    plan_instr(1, 1, 0, 1, 0, 8);
    run_plan();

    // Fetch timeout
    do_reset(); kick();
    plan_instr(0, 0, 0, T, 0, 5);
    run_plan();

    // Memory timeout
    do_reset(); kick();
    plan_instr(0, 1, 0, 0, T, 5);
    run_plan();

    // Conflicting load+store class
    do_reset(); kick();
    plan_instr(0, 1, 1, 0, 0, 3);
    run_plan();

    // Reset asserted mid-MEM drops everything at once
    do_reset(); kick();
    ifu_ready = 1; #1 chk("hand IF", 32'(stage), 32'd1);
    @(negedge clk); ifu_ready = 0; is_load = 1;
    #1 chk("hand ID", 32'(stage), 32'd2);
    @(negedge clk); is_load = 0;
    #1 chk("hand EX", 32'(stage), 32'd3);
    @(negedge clk); mem_ready = 0;
    #1 chk("hand MEM read level", 32'({stage, mre}), 32'({3'd4, 1'b1}));
    rst_n = 0;
    #1;
    chk("async reset stage", 32'(stage), 32'd0);
    chk("async reset memReadEnable", 32'(mre), 32'd0);
    chk("async reset retire_cnt", 32'(retire_cnt), 32'd0);
    @(negedge clk); rst_n = 1;
    #1 chk("after reset idle outputs", 32'(outs()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stage_controller.md
# stage_controller

Multi-cycle sequencer for the NPC core: walks each instruction through IF/ID/EX/MEM/WB, drives the instruction-fetch and data-memory handshakes, and emits the `stage`, `memReadEnable`, `memWriteEnable` and `halt` strobes consumed by the DPI bridge and the datapath. It sits between the decoder (instruction class flags) and the datapath write enables. It also counts retired instructions and traps stalled memory transactions.

## Interface
- `TIMEOUT_CYCLES`, 255: max wait cycles in IF or MEM before entering ERR; legal range 1..65535.
- `RETIRE_W`, 32: width of the retired-instruction counter.

- `clk`  in  1  core clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  leave IDLE and begin fetching
- `ifu_ready`  in  1  fetch data valid this cycle
- `mem_ready`  in  1  data memory done this cycle
- `halt_req`  in  1  decoder: ebreak (valid in ID)
- `is_load`  in  1  decoder: load (valid in ID)
- `is_store`  in  1  decoder: store (valid in ID)
- `stage`  out  3  current state encoding
- `ifu_req`  out  1  fetch request, level
- `ir_we`  out  1  latch instruction register, pulse
- `memReadEnable`  out  1  load request, level
- `memWriteEnable`  out  1  store request, level
- `pc_we`  out  1  update PC, pulse
- `rf_we`  out  1  regfile write, pulse
- `halt`  out  1  sticky halted flag
- `timeout_err`  out  1  sticky error flag
- `retire_cnt`  out  RETIRE_W  instructions retired

## Operation
- States and `stage` encoding: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, HALT=6, ERR=7.
- IDLE: all strobes 0; `start`=1 -> IF.
- IF: `ifu_req`=1. On `ifu_ready`=1, `ir_we`=1 in the same cycle, then -> ID.
- ID: sample `halt_req`, `is_load`, `is_store` into class registers.
  - `halt_req`=1 -> HALT. Halt wins over any other flag.
  - `is_load` and `is_store` both 1 -> ERR.
  - Otherwise -> EX.
- EX: one cycle. A load or store goes to MEM; anything else goes to WB.
- MEM: hold `memReadEnable` (load) or `memWriteEnable` (store) at 1 until the cycle in which `mem_ready`=1, then -> WB.
- WB: `pc_we`=1. `rf_we`=1 unless the class is store. `retire_cnt` increments by 1 and wraps modulo 2^RETIRE_W. Then -> IF.
- HALT: `halt`=1. Absorbing state; only reset leaves it. `start` is ignored.
- ERR: `timeout_err`=1. Absorbing state; only reset leaves it.
- Wait timer:
  - Counts cycles spent in IF with `ifu_ready`=0, or in MEM with `mem_ready`=0.
  - Clears on every state change.
  - When it reaches `TIMEOUT_CYCLES` with ready still low, the next state is ERR.
  - A ready arriving in that same cycle wins, and the normal transition is taken.
- `ifu_ready` and `mem_ready` are ignored outside IF and MEM respectively.

## Timing
- All outputs are Moore-decoded from registered state, except `ir_we`, which is `ifu_req & ifu_ready`.
- Reset values: `stage`=0 (IDLE), every strobe 0, `halt`=0, `timeout_err`=0, `retire_cnt`=0, timer=0, class registers=0.
- Latency with zero-wait memory:
  - ALU or jump instruction: 4 cycles (IF, ID, EX, WB).
  - Load or store: 5 cycles.
  - Each ready-low cycle in IF or MEM adds 1 cycle.
- `memReadEnable` and `memWriteEnable` are never both 1, and neither is 1 outside MEM.
- Each strobe rises once per transaction, which gives the DPI side a single posedge per access.
- `stage` changes at most once per clock.
- Reset assertion mid-transaction (any state) forces IDLE asynchronously and drops all strobes within the same cycle. No retire is counted for the aborted instruction.

## Structure
- Package `npc_ctrl_pkg` holds:
  - `stage_e` (3-bit enum with the encodings above);
  - an instruction-class struct {halt, load, store};
  - `STAGE_W`=3.
- The DPI bridge and datapath import `npc_ctrl_pkg` so they use the same `stage_e` encodings.
- Sub-module `wait_timer`:
  - parameterised width;
  - inputs: `clear`, `count_en`;
  - output: `expired`.
- The FSM and retire counter stay in `stage_controller`.

## Test plan
- Reset then `start`=1; ALU instruction with `ifu_ready` tied 1 -> `stage` sequence 1,2,3,5,1; `pc_we` and `rf_we` each high for exactly 1 cycle; `retire_cnt`=1 after WB.
- Load with `mem_ready` low for 3 cycles -> `memReadEnable` high exactly 4 cycles; `rf_we`=1 in WB; total latency 8 cycles.
- Store with `mem_ready`=1 immediately -> `memWriteEnable` high 1 cycle; `rf_we`=0 in WB; `memReadEnable` never asserted.
- `halt_req`=1 together with `is_load`=1 in ID -> next `stage`=6; `halt`=1; no MEM entry; `start` pulses afterwards have no effect.
- `TIMEOUT_CYCLES`=4:
  - `ifu_ready` held 0 -> ERR entered after 4 wait cycles; `timeout_err`=1 and sticky.
  - Rerun with `ifu_ready`=1 on the 4th wait cycle -> ID, no error.
- `rst_n` pulsed low during MEM -> `stage`=0 and `memReadEnable`=0 immediately; `retire_cnt` unchanged at 0; with RETIRE_W=4, 16 retires wrap the counter to 0.
